issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//  Parametrised issue-control unit between ID and the EXE pipes. Tracks pending GPR writes (RAW/WAW hazards).
//  Reserves write-back slots for NUM_PIPES fixed-latency pipes through a latency shift register.
//  Runs a request/grant WB handshake for one variable-latency pipe (DIV). Outputs a single issue decision per cycle.
// PARAMETERS
//  NUM_REGS   32            architectural GPR count; x0 never tracked
//  NUM_PIPES  4             one-hot pipe select width (0=ALU,1=LSU,2=MUL,3=DIV)
//  MAX_LAT    8             largest fixed latency; reservation vector is MAX_LAT+1 bits
//  PIPE_LAT   {0,3,2,1}     NUM_PIPES x 4b packed latencies, pipe i at [4i+:4]; 0 = variable-latency
//  VAR_PIPE   3             index of the variable-latency pipe; its PIPE_LAT entry must be 0
//  BYPASS_WB  1             1: a same-cycle WB to a source/dest register resolves that hazard
// PORTS
//  clk          in   1                clock
//  rst          in   1                reset, asynchronous, active-high
//  stall        in   1                core stall; no issue this cycle
//  flush        in   1                kill ID instruction this cycle; in-flight state untouched
//  var_flush    in   1                abort in-flight variable op
//  id_valid     in   1                ID holds a decoded instruction
//  id_pipe      in   NUM_PIPES        one-hot target pipe
//  id_rd_write  in   1                instruction writes id_rd
//  id_rd        in   $clog2(NUM_REGS) destination register
//  id_use_rs1   in   1                rs1 is read
//  id_rs1       in   $clog2(NUM_REGS) source register 1
//  id_use_rs2   in   1                rs2 is read
//  id_rs2       in   $clog2(NUM_REGS) source register 2
//  wb_en        in   1                register-file write this cycle
//  wb_rd        in   $clog2(NUM_REGS) register being written
//  var_wb_req   in   1                variable pipe result ready; held until granted
//  var_wb_grant out  1                variable pipe may write back this cycle
//  issue        out  1                instruction dispatched this cycle
//  conflict     out  1                hazard or slot conflict blocks the ID instruction
//  var_busy     out  1                variable op in flight
//  pending      out  NUM_REGS         pending-write bitmap (debug/verification)
// BEHAVIOUR
//  Reset (async): pending=0, resv=0, var_busy=0, var_rd=0. issue, conflict and var_wb_grant are 0 while rst is high.
//  L = PIPE_LAT[sel]. wr = id_rd_write && id_rd!=0. fwd(r) = BYPASS_WB && wb_en && wb_rd==r && r!=0.
//  Hazards:
//   raw1 = id_use_rs1 && pending[id_rs1] && !fwd(id_rs1); raw2 likewise for rs2.
//   waw  = wr && pending[id_rd] && !fwd(id_rd).
//  Slot and pipe conflicts:
//   slot = fixed pipe && wr && resv[L].
//   vblk = (var pipe && var_busy) || (fixed pipe && wr && var_wb_req && !var_wb_grant).
//   The vblk fixed-pipe term prevents DIV write-back starvation; grant occurs within MAX_LAT cycles.
//  conflict = id_valid && (raw1|raw2|waw|slot|vblk); issue = id_valid && !conflict && !stall && !flush.
//  issue is combinational, same cycle; all state updates on the next posedge.
//  resv[k] = WB port taken k cycles from now.
//   Each cycle: resv_next[k] = resv[k+1] (resv[MAX_LAT] gets 0), OR bit L-1 if issue to a fixed pipe with wr.
//  var_wb_grant = var_wb_req && !resv[0]. On grant: var_busy clears next cycle.
//  Issue to VAR_PIPE: var_busy<=1, var_rd<=id_rd.
//  pending:
//   Set on issue with wr; cleared on wb_en with wb_rd!=0.
//   Same-cycle set and clear on one register: set wins.
//   var_flush: clears var_busy and pending[var_rd].
//   var_flush has priority over a same-cycle grant; a same-cycle issue set still wins.
//  Non-writing instructions (stores, branches) reserve no slot and set no pending bit.
//  id_pipe not one-hot or zero is illegal; assertion required. x0 destinations are ignored everywhere.
// TESTING
//  - RAW: issue ALU rd=5; next cycle MUL rs1=5 -> conflict=1 until the wb_rd=5 cycle.
//    In that cycle issue=1 (BYPASS_WB=1), or one cycle later (BYPASS_WB=0).
//  - Slot collision: issue MUL rd=6 at t0 (slot 3), then LSU rd=7 at t0+1 (slot 2, needs resv[2]).
//    Expect conflict=1 at t0+1, issue=1 at t0+2.
//  - DIV handshake: issue DIV rd=9 -> var_busy=1; 2nd DIV -> conflict; ALU rd=1 issues.
//    var_wb_req while resv[0]=1 -> grant=0; next free cycle grant=1; var_busy=0 a cycle later.
//  - Starvation guard: var_wb_req held, back-to-back ALU writers.
//    Expect fixed-pipe writers blocked, grant within MAX_LAT cycles; non-writing ALU ops still issue.
//  - Simultaneous set/clear: wb_rd=4 and issue rd=4 in the same cycle -> pending[4]=1 afterwards.
//    flush=1 with a clean instruction -> issue=0 and no state change.
//  - Reset mid-operation: with pending=0x0000_0220, var_busy=1 and resv nonzero, assert rst asynchronously.
//    Expect all state 0 immediately, issue=0; first instruction after release issues.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Issue-control bundle between ID, write-back and the issue scoreboard.
// master = ID/write-back side driving requests, slave = the scoreboard.
interface issue_scoreboard_if #(
    parameter int NUM_REGS  = 32,
    parameter int NUM_PIPES = 4
);
    localparam int RW = $clog2(NUM_REGS);

    logic                 stall;
    logic                 flush;
    logic                 var_flush;
    logic                 id_valid;
    logic [NUM_PIPES-1:0] id_pipe;
    logic                 id_rd_write;
    logic [RW-1:0]        id_rd;
    logic                 id_use_rs1;
    logic [RW-1:0]        id_rs1;
    logic                 id_use_rs2;
    logic [RW-1:0]        id_rs2;
    logic                 wb_en;
    logic [RW-1:0]        wb_rd;
    logic                 var_wb_req;
    logic                 var_wb_grant;
    logic                 issue;
    logic                 conflict;
    logic                 var_busy;
    logic [NUM_REGS-1:0]  pending;

    modport master (
        output stall, flush, var_flush, id_valid, id_pipe, id_rd_write, id_rd,
               id_use_rs1, id_rs1, id_use_rs2, id_rs2, wb_en, wb_rd, var_wb_req,
        input  var_wb_grant, issue, conflict, var_busy, pending
    );

    modport slave (
        input  stall, flush, var_flush, id_valid, id_pipe, id_rd_write, id_rd,
               id_use_rs1, id_rs1, id_use_rs2, id_rs2, wb_en, wb_rd, var_wb_req,
        output var_wb_grant, issue, conflict, var_busy, pending
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks pending GPR writes, reserves write-back slots for
// the fixed-latency pipes and arbitrates write-back for the variable-latency
// pipe. Produces one combinational issue decision per cycle.
module issue_scoreboard #(
    parameter int                     NUM_REGS  = 32,
    parameter int                     NUM_PIPES = 4,
    parameter int                     MAX_LAT   = 8,
    parameter logic [4*NUM_PIPES-1:0] PIPE_LAT  = {4'd0, 4'd3, 4'd2, 4'd1},
    parameter int                     VAR_PIPE  = 3,
    parameter bit                     BYPASS_WB = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    issue_scoreboard_if.slave  bus
);
    localparam int RW   = $clog2(NUM_REGS);
    localparam int RV_W = MAX_LAT + 1;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_next;
    logic [RV_W-1:0]     resv;
    logic [RV_W-1:0]     resv_sh;
    logic [RV_W-1:0]     resv_set;
    logic                var_busy;
    logic [RW-1:0]       var_rd;

    logic [3:0]          lat;
    logic                is_var;
    logic                is_fixed;
    logic                wr;
    logic                raw1;
    logic                raw2;
    logic                waw;
    logic                slot;
    logic                vblk;
    logic                hazard;
    logic                grant;
    logic                issue_w;
    logic                do_resv;

    // Same-cycle write-back to r resolves a hazard on r when bypassing is on.
    function automatic logic fwd(input logic [RW-1:0] r, input logic en,
                                 input logic [RW-1:0] wr_r);
        return BYPASS_WB && en && (wr_r == r) && (r != '0);
    endfunction

    // Decode target pipe latency and hazard/conflict terms.
    always_comb begin
        lat = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (bus.id_pipe[i]) lat = lat | PIPE_LAT[4*i +: 4];
        end
        is_var   = bus.id_pipe[VAR_PIPE];
        is_fixed = (|bus.id_pipe) && !is_var;
        wr       = bus.id_rd_write && (bus.id_rd != '0);
        resv_sh  = resv >> lat;
        resv_set = (RV_W'(1) << lat) >> 1;

        raw1 = bus.id_use_rs1 && pending[bus.id_rs1] && !fwd(bus.id_rs1, bus.wb_en, bus.wb_rd);
        raw2 = bus.id_use_rs2 && pending[bus.id_rs2] && !fwd(bus.id_rs2, bus.wb_en, bus.wb_rd);
        waw  = wr && pending[bus.id_rd] && !fwd(bus.id_rd, bus.wb_en, bus.wb_rd);
        slot = is_fixed && wr && resv_sh[0];

        // A held DIV request blocks fixed writers until its grant, so DIV
        // cannot be starved of the write-back port.
        grant = !rst && bus.var_wb_req && !resv[0];
        vblk  = (is_var && var_busy) || (is_fixed && wr && bus.var_wb_req && !grant);

        hazard  = !rst && bus.id_valid && (raw1 || raw2 || waw || slot || vblk);
        issue_w = !rst && bus.id_valid && !hazard && !bus.stall && !bus.flush;
        do_resv = issue_w && is_fixed && wr;
    end

    // Pending bitmap next state: clears first, an issuing set wins last.
    always_comb begin
        pend_next = pending;
        if (bus.wb_en && bus.wb_rd != '0) pend_next[bus.wb_rd] = 1'b0;
        if (bus.var_flush && var_busy && var_rd != '0) pend_next[var_rd] = 1'b0;
        if (issue_w && wr) pend_next[bus.id_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            resv     <= '0;
            var_busy <= 1'b0;
            var_rd   <= '0;
        end else begin
            pending <= pend_next;
            resv    <= (resv >> 1) | (do_resv ? resv_set : '0);
            if (issue_w && is_var) begin
                var_busy <= 1'b1;
                var_rd   <= bus.id_rd;
            end else if (bus.var_flush || grant) begin
                var_busy <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // Flag illegal (non one-hot) pipe selects on a presented instruction.
    always_ff @(posedge clk) begin
        if (!rst && bus.id_valid) begin
            assert ($onehot(bus.id_pipe))
            else $error("issue_scoreboard: id_pipe not one-hot: %b", bus.id_pipe);
        end
    end
`endif

    assign bus.issue        = issue_w;
    assign bus.conflict     = hazard;
    assign bus.var_wb_grant = grant;
    assign bus.var_busy     = var_busy;
    assign bus.pending      = pending;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_issue_scoreboard;
    localparam logic [3:0] ALU = 4'b0001;
    localparam logic [3:0] LSU = 4'b0010;
    localparam logic [3:0] MUL = 4'b0100;
    localparam logic [3:0] DIV = 4'b1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    issue_scoreboard_if #(.NUM_REGS(32), .NUM_PIPES(4)) bus();

    issue_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  p;
        logic        w;
        logic [4:0]  rd;
        logic        u1;
        logic [4:0]  r1;
        logic        u2;
        logic [4:0]  r2;
        logic [2:0]  ctl;   // {stall, flush, var_flush}
        logic        we;
        logic [4:0]  wbr;
        logic        rq;
        logic [3:0]  ex;    // {issue, conflict, grant, var_busy}
        logic [31:0] pd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic v, input logic [3:0] p, input logic w,
                       input logic [4:0] rd, input logic u1, input logic [4:0] r1,
                       input logic u2, input logic [4:0] r2, input logic [2:0] ctl,
                       input logic we, input logic [4:0] wbr, input logic rq,
                       input logic [3:0] ex, input logic [31:0] pd);
        vec_t t;
        t.v = v; t.p = p; t.w = w; t.rd = rd; t.u1 = u1; t.r1 = r1;
        t.u2 = u2; t.r2 = r2; t.ctl = ctl; t.we = we; t.wbr = wbr;
        t.rq = rq; t.ex = ex; t.pd = pd;
        vq.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid    = t.v;
        bus.id_pipe     = t.p;
        bus.id_rd_write = t.w;
        bus.id_rd       = t.rd;
        bus.id_use_rs1  = t.u1;
        bus.id_rs1      = t.r1;
        bus.id_use_rs2  = t.u2;
        bus.id_rs2      = t.r2;
        bus.stall       = t.ctl[2];
        bus.flush       = t.ctl[1];
        bus.var_flush   = t.ctl[0];
        bus.wb_en       = t.we;
        bus.wb_rd       = t.wbr;
        bus.var_wb_req  = t.rq;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ex, input logic [31:0] pd);
        check({tag, ".issue"},    32'(bus.issue),        32'(ex[3]));
        check({tag, ".conflict"}, 32'(bus.conflict),     32'(ex[2]));
        check({tag, ".grant"},    32'(bus.var_wb_grant), 32'(ex[1]));
        check({tag, ".var_busy"}, 32'(bus.var_busy),     32'(ex[0]));
        check({tag, ".pending"},  bus.pending,           pd);
    endtask

    vec_t idle;

    initial begin
        idle = '{v:0, p:ALU, w:0, rd:0, u1:0, r1:0, u2:0, r2:0, ctl:3'b000,
                 we:0, wbr:0, rq:0, ex:4'b0000, pd:32'h0};

        //   v  pipe w  rd u1 r1 u2 r2 ctl     we wbr rq  {iss,cf,gnt,bsy} pending
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 32'h0000_0000);
        // RAW on x5 resolved by same-cycle write-back
        add(1, ALU, 1,  5, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 32'h0000_0000);
        add(1, MUL, 1,  6, 1, 5, 0, 0, 3'b000, 0, 0, 0, 4'b0100, 32'h0000_0020);
        add(1, MUL, 1,  6, 1, 5, 0, 0, 3'b000, 0, 0, 0, 4'b0100, 32'h0000_0020);
        add(1, MUL, 1,  6, 1, 5, 0, 0, 3'b000, 1, 5, 0, 4'b1000, 32'h0000_0020);
        // slot collision: LSU at t0+1 needs resv[2] taken by MUL
        add(1, LSU, 1,  7, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b0100, 32'h0000_0040);
        add(1, LSU, 1,  7, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 32'h0000_0040);
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b000, 1, 6, 0, 4'b0000, 32'h0000_00C0);
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b000, 1, 7, 0, 4'b0000, 32'h0000_0080);
        // simultaneous set/clear on x4, then WAW, flush and stall
        add(1, ALU, 1,  4, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 32'h0000_0000);
        add(1, ALU, 1,  4, 0, 0, 0, 0, 3'b000, 1, 4, 0, 4'b1000, 32'h0000_0010);
        add(1, ALU, 1,  4, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b0100, 32'h0000_0010);
        add(1, ALU, 1,  8, 0, 0, 0, 0, 3'b010, 0, 0, 0, 4'b0000, 32'h0000_0010);
        add(1, ALU, 1,  8, 0, 0, 0, 0, 3'b100, 0, 0, 0, 4'b0000, 32'h0000_0010);
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b000, 1, 4, 0, 4'b0000, 32'h0000_0010);
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 32'h0000_0000);
        // DIV handshake
        add(1, DIV, 1,  9, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 32'h0000_0000);
        add(1, DIV, 1, 10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b0101, 32'h0000_0200);
        add(1, ALU, 1,  1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1001, 32'h0000_0200);
        add(1, ALU, 1,  2, 0, 0, 0, 0, 3'b000, 0, 0, 1, 4'b0101, 32'h0000_0202);
        add(1, ALU, 0,  0, 1, 3, 0, 0, 3'b000, 1, 1, 1, 4'b1011, 32'h0000_0202);
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b000, 1, 9, 0, 4'b0000, 32'h0000_0200);
        // starvation guard: held request blocks ALU writer until granted
        add(1, ALU, 1,  3, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 32'h0000_0000);
        add(1, ALU, 1, 11, 0, 0, 0, 0, 3'b000, 0, 0, 1, 4'b0100, 32'h0000_0008);
        add(1, ALU, 1, 11, 0, 0, 0, 0, 3'b000, 1, 3, 1, 4'b1010, 32'h0000_0008);
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b000, 1, 11, 0, 4'b0000, 32'h0000_0800);
        // var_flush with same-cycle issue; var_flush over grant
        add(1, DIV, 1, 12, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 32'h0000_0000);
        add(1, ALU, 1, 13, 0, 0, 0, 0, 3'b001, 0, 0, 0, 4'b1001, 32'h0000_1000);
        add(1, DIV, 1, 12, 0, 0, 0, 0, 3'b000, 1, 13, 0, 4'b1000, 32'h0000_2000);
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 4'b0011, 32'h0000_1000);
        // x0 destinations are ignored
        add(1, ALU, 1,  0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 32'h0000_0000);
        add(1, MUL, 1,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b1000, 32'h0000_0000);
        add(0, ALU, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'b0000, 32'h0000_0000);

        // outputs held low during reset even with a valid instruction
        drive(idle);
        bus.id_valid    = 1'b1;
        bus.id_rd_write = 1'b1;
        bus.id_rd       = 5'd3;
        bus.var_wb_req  = 1'b1;
        #2;
        check_all("reset", 4'b0000, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vq[i]);
            #2;
            check_all($sformatf("v%0d", i), vq[i].ex, vq[i].pd);
        end

        // reset mid-operation: build pending=0x220, var_busy=1, resv nonzero
        @(negedge clk);
        drive(idle);
        bus.id_valid = 1'b1; bus.id_pipe = MUL; bus.id_rd_write = 1'b1; bus.id_rd = 5'd5;
        #2;
        check("mid.mul_issue", 32'(bus.issue), 32'd1);
        @(negedge clk);
        bus.id_pipe = DIV; bus.id_rd = 5'd9;
        #2;
        check("mid.div_issue", 32'(bus.issue), 32'd1);
        @(negedge clk);
        bus.id_pipe = ALU; bus.id_rd = 5'd7; bus.var_wb_req = 1'b1;
        #2;
        check("mid.pending_before", bus.pending, 32'h0000_0220);
        check("mid.busy_before", 32'(bus.var_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.pending_rst", bus.pending, 32'h0);
        check("mid.busy_rst", 32'(bus.var_busy), 32'd0);
        check("mid.issue_rst", 32'(bus.issue), 32'd0);
        check("mid.conflict_rst", 32'(bus.conflict), 32'd0);
        check("mid.grant_rst", 32'(bus.var_wb_grant), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        // resv[0] would hold the MUL slot here had reset not cleared it
        check("post.issue", 32'(bus.issue), 32'd1);
        check("post.grant", 32'(bus.var_wb_grant), 32'd1);
        check("post.pending", bus.pending, 32'h0);
        @(negedge clk);
        drive(idle);
        #2;
        check("post.pending_set", bus.pending, 32'h0000_0080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
